soc_req_res_ctrl: RTL

//  Avalon-MM slave sequencing a four-phase request/response handshake between HPS software and a fabric worker.

---
 rtl/soc_req_res_pkg.sv | 26 ++
 rtl/soc_req_res_sync.sv | 21 ++
 rtl/soc_req_res_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/soc_req_res_pkg.sv
// Shared definitions for the request/response handshake controller:
// FSM state encoding, Avalon register offsets and CTRL/STAT bit positions.
package soc_req_res_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STAT    = 2'd1;
  localparam logic [1:0] ADDR_RESULT  = 2'd2;
  localparam logic [1:0] ADDR_TMO_LIM = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_TMO      = 2;
  localparam int STAT_STATE_LO = 3;
  localparam int STAT_STATE_HI = 4;

endpackage

// File: rtl/soc_req_res_sync.sv
// Reset-to-0 multi-flop synchronizer bringing the worker's res_in into clk.
module soc_req_res_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/soc_req_res_ctrl.sv
// Avalon-MM slave sequencing a four-phase req/res handshake with a fabric
// worker: register file, handshake FSM, optional timeout timer, read mux.
// Optional timeout feature: define SOC_REQ_RES_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | no request outstanding, waiting for START
//  REQ   | req_out high, waiting for synchronized res_in to rise
//  REL   | req_out low, waiting for synchronized res_in to fall
module soc_req_res_ctrl
  import soc_req_res_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
`ifdef SOC_REQ_RES_TIMEOUT_EN
  ,
  parameter logic [31:0] TMO_DEFAULT = 32'hFFFF_FFFF
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              req_out,
  input  logic              res_in,
  input  logic [DATA_W-1:0] res_data
);

  state_e              state_q, state_d;
  logic                req_out_q, req_out_d;
  logic                aborted_q, aborted_d;
  logic                irq_en_q;
  logic                done_q, done_d, done_set;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                res_s;
  logic                wr, wr_ctrl, wr_stat, start_req, abort_req;
  logic                tmo_bit;

  soc_req_res_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (res_in),
    .sync_o  (res_s)
  );

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == ADDR_CTRL);
  assign wr_stat   = wr & (address == ADDR_STAT);
  // ABORT in the same write suppresses START.
  assign abort_req = wr_ctrl & writedata[CTRL_ABORT];
  assign start_req = wr_ctrl & writedata[CTRL_START] & ~writedata[CTRL_ABORT];

`ifdef SOC_REQ_RES_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic [31:0] tmo_lim_q;
  logic        tmo_q, tmo_d, tmo_set;
  assign tmo_bit = tmo_q;
`else
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:3];
  assign tmo_bit      = 1'b0;
`endif

  // Handshake next-state logic; a response seen in REQ beats ABORT and timeout.
  always_comb begin
    state_d   = state_q;
    req_out_d = req_out_q;
    aborted_d = aborted_q;
    result_d  = result_q;
    done_set  = 1'b0;
`ifdef SOC_REQ_RES_TIMEOUT_EN
    timer_d   = timer_q;
    tmo_set   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d   = ST_REQ;
          req_out_d = 1'b1;
          aborted_d = 1'b0;
`ifdef SOC_REQ_RES_TIMEOUT_EN
          timer_d   = '0;
`endif
        end
      end
      ST_REQ: begin
        if (res_s) begin
          result_d  = res_data;
          req_out_d = 1'b0;
          state_d   = ST_REL;
        end else if (abort_req) begin
          req_out_d = 1'b0;
          aborted_d = 1'b1;
          state_d   = ST_REL;
        end
`ifdef SOC_REQ_RES_TIMEOUT_EN
        else if ((tmo_lim_q != 32'd0) && (timer_q == tmo_lim_q)) begin
          tmo_set   = 1'b1;
          req_out_d = 1'b0;
          aborted_d = 1'b1;
          state_d   = ST_REL;
        end else begin
          timer_d   = timer_q + 32'd1;
        end
`endif
      end
      ST_REL: begin
        if (!res_s) begin
          done_set = ~aborted_q;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        req_out_d = 1'b0;
      end
    endcase
  end

  // Sticky status flags: a hardware set in the same cycle as W1C wins.
  always_comb begin
    done_d = done_q;
    if (wr_stat && writedata[STAT_DONE]) done_d = 1'b0;
    if (done_set)                        done_d = 1'b1;
`ifdef SOC_REQ_RES_TIMEOUT_EN
    tmo_d = tmo_q;
    if (wr_stat && writedata[STAT_TMO]) tmo_d = 1'b0;
    if (tmo_set)                        tmo_d = 1'b1;
`endif
  end

  // State, handshake and register-file flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      req_out_q <= 1'b0;
      aborted_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_out_q <= req_out_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      result_q  <= result_d;
      if (wr_ctrl) irq_en_q <= writedata[CTRL_IRQ_EN];
    end
  end

`ifdef SOC_REQ_RES_TIMEOUT_EN
  // Timeout timer, limit register and TMO flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      tmo_lim_q <= TMO_DEFAULT;
      tmo_q     <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
      if (wr && (address == ADDR_TMO_LIM)) tmo_lim_q <= writedata;
    end
  end
`endif

  // Zero-wait-state read mux; unmapped bits read as 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[CTRL_IRQ_EN] = irq_en_q;
      ADDR_STAT: begin
        readdata[STAT_BUSY]                   = (state_q != ST_IDLE);
        readdata[STAT_DONE]                   = done_q;
        readdata[STAT_TMO]                    = tmo_bit;
        readdata[STAT_STATE_HI:STAT_STATE_LO] = state_q;
      end
      ADDR_RESULT: readdata = 32'(result_q);
`ifdef SOC_REQ_RES_TIMEOUT_EN
      ADDR_TMO_LIM: readdata = tmo_lim_q;
`endif
      default:     readdata = '0;
    endcase
  end

  assign irq     = irq_en_q & (done_q | tmo_bit);
  assign req_out = req_out_q;

endmodule
